// File: rtl/tlc_phase_sched.sv
// Six-phase junction scheduler with pedestrian walk insertion after P5.
// Optional flashing mode is compiled in when TLC_FLASH_EN is defined.
module tlc_phase_sched #(
   parameter int unsigned TICK_DIV = 4,
   parameter logic [7:0]  T0       = 8'd8,
   parameter logic [7:0]  T1       = 8'd8,
   parameter logic [7:0]  T2       = 8'd3,
   parameter logic [7:0]  T3       = 8'd3,
   parameter logic [7:0]  T4       = 8'd3,
   parameter logic [7:0]  T5       = 8'd3,
   parameter logic [7:0]  T_PED    = 8'd6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        ped_req,
`ifdef TLC_FLASH_EN
   input  logic        flash,
`endif
   output logic [11:0] led,
   output logic [2:0]  phase,
   output logic        ped_walk,
   output logic        ped_ack,
   output logic        phase_start
);

   typedef enum logic [2:0] {
      S_P0    = 3'd0,
      S_P1    = 3'd1,
      S_P2    = 3'd2,
      S_P3    = 3'd3,
      S_P4    = 3'd4,
      S_P5    = 3'd5,
      S_PW    = 3'd6,
      S_FLASH = 3'd7
   } state_t;

   localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);

   state_t      state_q, state_d, next_s;
   logic [15:0] pre_q, pre_d;
   logic [7:0]  dwell_q, dwell_d;
   logic        latch_q, latch_d;
   logic [11:0] led_q, led_d;
   logic        walk_q, walk_d;
   logic        ack_q, ack_d;
   logic        start_q, start_d;
   logic        tick, enter;

   // A zero dwell is treated as one tick, so the load value floors at 0.
   function automatic logic [7:0] dwell_load(input state_t s);
      logic [7:0] t;
      case (s)
         S_P0:    t = T0;
         S_P1:    t = T1;
         S_P2:    t = T2;
         S_P3:    t = T3;
         S_P4:    t = T4;
         S_P5:    t = T5;
         S_PW:    t = T_PED;
         default: t = 8'd1;
      endcase
      return (t == 8'd0) ? 8'd0 : t - 8'd1;
   endfunction

   function automatic logic [11:0] led_of(input state_t s);
      logic [11:0] v;
      case (s)
         S_P0:    v = 12'h514;
         S_P1:    v = 12'h8A2;
         S_P2:    v = 12'h014;
         S_P3:    v = 12'h0A0;
         S_P4:    v = 12'h500;
         S_P5:    v = 12'h802;
         S_FLASH: v = 12'h802;
         default: v = 12'h000;
      endcase
      return v;
   endfunction

   always_comb begin
      tick    = en && (pre_q == PRE_MAX);
      state_d = state_q;
      pre_d   = pre_q;
      dwell_d = dwell_q;
      led_d   = led_q;
      walk_d  = walk_q;
      ack_d   = 1'b0;
      start_d = 1'b0;
      latch_d = latch_q | ped_req;
      enter   = 1'b0;

      case (state_q)
         S_P5:    next_s = latch_q ? S_PW : S_P0;
         S_PW:    next_s = S_P0;
         default: next_s = state_t'(state_q + 3'd1);
      endcase

      if (en)
         pre_d = tick ? 16'd0 : pre_q + 16'd1;

      case (state_q)
         S_P0, S_P1, S_P2, S_P3, S_P4, S_P5, S_PW: begin
            if (tick) begin
               if (dwell_q == 8'd0)
                  enter = 1'b1;
               else
                  dwell_d = dwell_q - 8'd1;
            end
         end
`ifdef TLC_FLASH_EN
         S_FLASH: begin
            if (tick)
               led_d = (led_q == 12'h802) ? 12'h000 : 12'h802;
         end
`endif
         default: begin
            state_d = S_P0;
            dwell_d = dwell_load(S_P0);
            pre_d   = 16'd0;
            led_d   = 12'h514;
            walk_d  = 1'b0;
         end
      endcase

`ifdef TLC_FLASH_EN
      // Flash overrides any pending phase advance, including the P5->PW decision.
      if (flash && state_q != S_FLASH) begin
         enter  = 1'b1;
         next_s = S_FLASH;
      end else if (!flash && state_q == S_FLASH) begin
         enter  = 1'b1;
         next_s = S_P0;
      end
`endif

      if (enter) begin
         state_d = next_s;
         dwell_d = dwell_load(next_s);
         pre_d   = 16'd0;
         led_d   = led_of(next_s);
         walk_d  = (next_s == S_PW);
         ack_d   = (next_s == S_PW);
         start_d = 1'b1;
         if (next_s == S_PW)
            latch_d = ped_req;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_P0;
         pre_q   <= 16'd0;
         dwell_q <= dwell_load(S_P0);
         latch_q <= 1'b0;
         led_q   <= 12'h514;
         walk_q  <= 1'b0;
         ack_q   <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         dwell_q <= dwell_d;
         latch_q <= latch_d;
         led_q   <= led_d;
         walk_q  <= walk_d;
         ack_q   <= ack_d;
         start_q <= start_d;
      end
   end

   assign led         = led_q;
   assign phase       = state_q;
   assign ped_walk    = walk_q;
   assign ped_ack     = ack_q;
   assign phase_start = start_q;

endmodule

// File: tb/tb_tlc_phase_sched.sv
// Bench for tlc_phase_sched: directed scenarios plus random traffic, scored per cycle
// against a phase-length reference model. Flash scenarios run when TLC_FLASH_EN is defined.
module tb_tlc_phase_sched;
   localparam int TD = 2;
   localparam int TN = 2;
   localparam int TP = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        ped_req = 1'b0;
`ifdef TLC_FLASH_EN
   logic        flash = 1'b0;
`endif
   logic [11:0] led;
   logic [2:0]  phase;
   logic        ped_walk, ped_ack, phase_start;

   always #5 clk = ~clk;

   tlc_phase_sched #(
      .TICK_DIV(TD), .T0(8'(TN)), .T1(8'(TN)), .T2(8'(TN)), .T3(8'(TN)),
      .T4(8'(TN)), .T5(8'(TN)), .T_PED(8'(TP))
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req),
`ifdef TLC_FLASH_EN
      .flash(flash),
`endif
      .led(led), .phase(phase), .ped_walk(ped_walk), .ped_ack(ped_ack),
      .phase_start(phase_start)
   );

   typedef struct packed {
      logic [2:0]  ph;
      logic [11:0] led;
      logic        walk;
      logic        ack;
      logic        start;
   } obs_t;

   obs_t sbq[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Reference model: each phase lasts a number of enabled cycles; no prescaler detail.
   int          m_ph = 0;
   int          m_rem = TN * TD;
   int          m_fcnt = 0;
   bit          m_latch = 0;
   bit          m_start = 0;
   bit          m_ack = 0;
   logic [11:0] m_fled = 12'h802;

   function automatic logic [11:0] pat(input int p);
      logic [11:0] v;
      case (p)
         0:       v = 12'h514;
         1:       v = 12'h8A2;
         2:       v = 12'h014;
         3:       v = 12'h0A0;
         4:       v = 12'h500;
         5:       v = 12'h802;
         default: v = 12'h000;
      endcase
      return v;
   endfunction

   function automatic int plen(input int p);
      return ((p == 6) ? TP : TN) * TD;
   endfunction

   task automatic m_enter(input int n);
      m_ph    = n;
      m_rem   = plen(n);
      m_start = 1;
      m_ack   = (n == 6);
      m_fcnt  = 0;
      m_fled  = 12'h802;
   endtask

   task automatic model_step(input bit r, input bit e, input bit p, input bit f);
      bit nl;
      int nxt;
      m_start = 0;
      m_ack   = 0;
      if (!r) begin
         m_ph    = 0;
         m_rem   = plen(0);
         m_latch = 0;
         return;
      end
      nl = m_latch | p;
      if (f && m_ph != 7) begin
         m_enter(7);
      end else if (!f && m_ph == 7) begin
         m_enter(0);
      end else if (m_ph == 7) begin
         if (e) begin
            m_fcnt++;
            if (m_fcnt == TD) begin
               m_fcnt = 0;
               m_fled = (m_fled == 12'h000) ? 12'h802 : 12'h000;
            end
         end
      end else if (e) begin
         m_rem--;
         if (m_rem == 0) begin
            if (m_ph < 5)       nxt = m_ph + 1;
            else if (m_ph == 5) nxt = m_latch ? 6 : 0;
            else                nxt = 0;
            m_enter(nxt);
            if (nxt == 6) nl = p;
         end
      end
      m_latch = nl;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, push the model's post-edge outputs, return just after the edge.
   task automatic step(input bit r, input bit e, input bit p, input bit f);
      obs_t x;
      @(negedge clk);
      rst_n   = r;
      en      = e;
      ped_req = p;
`ifdef TLC_FLASH_EN
      flash   = f;
`endif
      model_step(r, e, p, f);
      x.ph    = 3'(m_ph);
      x.led   = (m_ph == 7) ? m_fled : pat(m_ph);
      x.walk  = (m_ph == 6);
      x.ack   = m_ack;
      x.start = m_start;
      sbq.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic run_until(input logic [2:0] ph, input bit p, input string name);
      bit hit = 0;
      for (int i = 0; i < 200; i++) begin
         step(1, 1, p, 0);
         if (phase == ph) begin
            hit = 1;
            break;
         end
      end
      check({name, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic pass_after_p5(input bit p, output logic [2:0] nx);
      int n = 0;
      run_until(3'd5, 1'b0, "reach_p5");
      while (phase == 3'd5 && n < 50) begin
         step(1, 1, p, 0);
         n++;
      end
      nx = phase;
   endtask

   // Monitor: compares every presented output cycle against the scoreboard.
   initial begin
      obs_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = {phase, led, ped_walk, ped_ack, phase_start};
            n_checks++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL scoreboard t=%0t: got ph=%0d led=%h walk=%b ack=%b start=%b, expected ph=%0d led=%h walk=%b ack=%b start=%b",
                        $time, a.ph, a.led, a.walk, a.ack, a.start,
                        e.ph, e.led, e.walk, e.ack, e.start);
            end
            if (e.start)
               $display("t=%0t phase entry: ph=%0d led=%h walk=%b ack=%b", $time,
                        phase, led, ped_walk, ped_ack);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         pw_len;
      logic [2:0] nx;
      bit         r, e, p, f;

      // Reset state
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      check("rst_led", 32'(led), 32'h514);
      check("rst_phase", 32'(phase), 32'd0);
      check("rst_walk", 32'(ped_walk), 32'd0);
      check("rst_ack", 32'(ped_ack), 32'd0);
      check("rst_start", 32'(phase_start), 32'd0);

      // Sequencing: 4 cycles per phase with TICK_DIV=2, Tn=2
      for (int k = 1; k <= 28; k++) begin
         step(1, 1, 0, 0);
         check($sformatf("seq_led[%0d]", k), 32'(led), 32'(pat((k / 4) % 6)));
         check($sformatf("seq_start[%0d]", k), 32'(phase_start), 32'((k % 4) == 0));
      end

      // Pedestrian service from a one-cycle request in P2
      run_until(3'd2, 1'b0, "reach_p2");
      step(1, 1, 1, 0);
      run_until(3'd6, 1'b0, "reach_pw");
      check("pw_led", 32'(led), 32'h000);
      check("pw_walk", 32'(ped_walk), 32'd1);
      check("pw_ack_first", 32'(ped_ack), 32'd1);
      pw_len = 1;
      while (phase == 3'd6 && pw_len < 20) begin
         step(1, 1, 0, 0);
         if (phase == 3'd6) begin
            pw_len++;
            check("pw_ack_later", 32'(ped_ack), 32'd0);
            check("pw_walk_hold", 32'(ped_walk), 32'd1);
         end
      end
      check("pw_len", 32'(pw_len), 32'd6);
      check("pw_exit_phase", 32'(phase), 32'd0);
      pass_after_p5(1'b0, nx);
      check("no_pw_repeat", 32'(nx), 32'd0);

      // Request held across the PW-entry edge is served again next pass
      pass_after_p5(1'b1, nx);
      check("simul_pw", 32'(nx), 32'd6);
      pass_after_p5(1'b0, nx);
      check("simul_pw_repeat", 32'(nx), 32'd6);
      pass_after_p5(1'b0, nx);
      check("simul_then_none", 32'(nx), 32'd0);

      // Enable freeze in the last cycle of P1
      run_until(3'd1, 1'b0, "reach_p1");
      repeat (3) step(1, 1, 0, 0);
      check("frz_pre", 32'(phase), 32'd1);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0, 0);
         check("frz_phase", 32'(phase), 32'd1);
         check("frz_led", 32'(led), 32'h8A2);
      end
      step(1, 1, 0, 0);
      check("frz_resume_phase", 32'(phase), 32'd2);
      check("frz_resume_start", 32'(phase_start), 32'd1);

      // Reset in the middle of PW clears the latch
      step(1, 1, 1, 0);
      run_until(3'd6, 1'b0, "reach_pw2");
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      check("rstpw_phase", 32'(phase), 32'd0);
      check("rstpw_led", 32'(led), 32'h514);
      check("rstpw_walk", 32'(ped_walk), 32'd0);
      check("rstpw_start", 32'(phase_start), 32'd0);
      pass_after_p5(1'b0, nx);
      check("rstpw_latch_clear", 32'(nx), 32'd0);

`ifdef TLC_FLASH_EN
      run_until(3'd3, 1'b0, "reach_p3");
      step(1, 1, 0, 1);
      check("fl_phase", 32'(phase), 32'd7);
      check("fl_led0", 32'(led), 32'h802);
      check("fl_start", 32'(phase_start), 32'd1);
      step(1, 1, 0, 1);
      check("fl_led1", 32'(led), 32'h802);
      step(1, 1, 0, 1);
      check("fl_led2", 32'(led), 32'h000);
      step(1, 1, 0, 1);
      check("fl_led3", 32'(led), 32'h000);
      step(1, 1, 0, 1);
      check("fl_led4", 32'(led), 32'h802);
      step(1, 1, 0, 0);
      check("fl_exit_phase", 32'(phase), 32'd0);
      check("fl_exit_start", 32'(phase_start), 32'd1);
      repeat (3) step(1, 1, 0, 0);
      check("fl_p0_hold", 32'(phase), 32'd0);
      step(1, 1, 0, 0);
      check("fl_p0_done", 32'(phase), 32'd1);
`endif

      // Random traffic scored by the monitor
      f = 0;
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(0, 199) != 0);
         e = ($urandom_range(0, 9) < 8);
         p = ($urandom_range(0, 19) == 0);
`ifdef TLC_FLASH_EN
         if ($urandom_range(0, 99) == 0) f = ~f;
`endif
         step(r, e, p, f);
      end

      @(negedge clk);
      check("sb_drained", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
